// File: rtl/btn_cmd_ctrl.sv
// Button command controller: converts debounced button levels into press and
// hold-to-repeat events, arbitrates them round-robin and queues them in a FWFT FIFO.
module btn_cmd_ctrl #(
    parameter int N_BTN            = 4,
    parameter int REPEAT_DELAY_CYC = 12_500_000,
    parameter int REPEAT_RATE_CYC  = 2_500_000,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_level,
    input  logic [N_BTN-1:0]         rpt_en,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [$clog2(N_BTN)-1:0] cmd_id,
    output logic                     cmd_repeat,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int ID_W    = $clog2(N_BTN);
    localparam int CNT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                  : REPEAT_RATE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  DELAY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0]  RATE_LAST  = CNT_W'(REPEAT_RATE_CYC - 1);
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(N_BTN - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT   = FCNT_W'(FIFO_DEPTH);
    localparam logic [N_BTN-1:0]  ONE_HOT0   = {{(N_BTN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } btn_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            rpt;
    } cmd_t;

    btn_state_t        state_q [N_BTN];
    btn_state_t        state_d [N_BTN];
    logic [CNT_W-1:0]  cnt_q   [N_BTN];
    logic [CNT_W-1:0]  cnt_d   [N_BTN];
    logic [N_BTN-1:0]  prev_q;
    logic [N_BTN-1:0]  evt;
    logic [N_BTN-1:0]  evt_rpt;

    logic [N_BTN-1:0]  pend_q;
    logic [N_BTN-1:0]  pend_rpt_q;
    logic [N_BTN-1:0]  pend_keep;
    logic [N_BTN-1:0]  pend_d;
    logic [N_BTN-1:0]  pend_rpt_d;
    logic [N_BTN-1:0]  drop;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [N_BTN-1:0]  grant_oh;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W:0]     scan_sum;
    logic [ID_W-1:0]   scan_idx;

    cmd_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_full;
    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Per-button FSM: state register
    // ------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q <= btn_level;
        end
    end

    // Per-button FSM: next state and counter; a released button always wins.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!btn_level[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    IDLE: begin
                        if (!prev_q[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = '0;
                        end
                    end
                    HOLD: begin
                        if (!rpt_en[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == DELAY_LAST) begin
                            state_d[i] = RPT;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    RPT: begin
                        if (!rpt_en[i]) begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == RATE_LAST) begin
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Per-button FSM: event outputs
    always_comb begin
        evt     = '0;
        evt_rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_level[i]) begin
                unique case (state_q[i])
                    IDLE:    evt[i] = !prev_q[i];
                    HOLD:    evt[i] = rpt_en[i] && (cnt_q[i] == DELAY_LAST);
                    RPT:     evt[i] = rpt_en[i] && (cnt_q[i] == RATE_LAST);
                    default: evt[i] = 1'b0;
                endcase
            end
            evt_rpt[i] = (state_q[i] != IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pending slot at or above rr_ptr, wrapping
    // ------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (scan_sum >= (ID_W + 1)'(N_BTN)) begin
                scan_sum = scan_sum - (ID_W + 1)'(N_BTN);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!fifo_full && !grant_vld && pend_q[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant_oh = grant_vld ? (ONE_HOT0 << grant_idx) : '0;

    // A slot granted this cycle is free again, so a coincident event refills it.
    always_comb begin
        pend_keep  = pend_q & ~grant_oh;
        pend_d     = pend_keep;
        pend_rpt_d = pend_rpt_q;
        drop       = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (evt[i]) begin
                if (pend_keep[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_d[i]     = 1'b1;
                    pend_rpt_d[i] = evt_rpt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_rpt_q <= '0;
            rr_ptr     <= '0;
            ovf        <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_rpt_q <= pend_rpt_d;
            if (grant_vld) begin
                rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            end
            if (|drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign cmd_valid = (fifo_cnt != '0);
    assign push      = grant_vld;
    assign pop       = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: storage is not reset; the count qualifies it and the outputs are gated below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant_idx, pend_rpt_q[grant_idx]};
        end
    end

    assign cmd_id     = cmd_valid ? mem[rd_ptr].id  : '0;
    assign cmd_repeat = cmd_valid ? mem[rd_ptr].rpt : 1'b0;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Self-checking bench for btn_cmd_ctrl: directed scenarios with fixed expectations
// plus randomized traffic scored against an event-level reference model.
module tb_btn_cmd_ctrl;

    localparam int N     = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 5;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_level;
    logic [N-1:0] rpt_en;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_id;
    logic         cmd_repeat;
    logic         ovf;
    logic         ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    btn_cmd_ctrl #(
        .N_BTN           (N),
        .REPEAT_DELAY_CYC(DELAY),
        .REPEAT_RATE_CYC (RATE),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .rpt_en    (rpt_en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_repeat(cmd_repeat),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a button fires at its rising edge and then whenever its
    // run of enabled held cycles reaches DELAY, DELAY+RATE, DELAY+2*RATE, ...
    // ------------------------------------------------------------------
    typedef struct {
        int id;
        bit rpt;
    } ent_t;

    ent_t m_q[$];
    bit   m_pend[N];
    bit   m_prpt[N];
    bit   m_prev[N];
    bit   m_held[N];
    int   m_run[N];
    bit   m_ev[N];
    bit   m_evr[N];
    int   m_ptr;
    bit   m_ovf;
    int   m_g;
    bit   m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_prpt[i] = 0; m_prev[i] = 0;
                m_held[i] = 0; m_run[i] = 0;
            end
            m_ptr = 0;
            m_ovf = 0;
        end else begin
            m_g = -1;
            if (m_q.size() < DEPTH) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && m_pend[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                end
            end
            for (int i = 0; i < N; i++) begin
                m_ev[i]  = 0;
                m_evr[i] = 0;
                if (!btn_level[i]) begin
                    m_held[i] = 0;
                    m_run[i]  = 0;
                end else if (!m_held[i]) begin
                    if (!m_prev[i]) begin
                        m_ev[i]   = 1;
                        m_held[i] = 1;
                        m_run[i]  = 0;
                    end
                end else if (!rpt_en[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] >= DELAY && (m_run[i] - DELAY) % RATE == 0) begin
                        m_ev[i]  = 1;
                        m_evr[i] = 1;
                    end
                end
            end
            if (m_q.size() != 0 && cmd_ready) void'(m_q.pop_front());
            if (m_g >= 0) begin
                m_q.push_back('{m_g, m_prpt[m_g]});
                m_pend[m_g] = 0;
                m_ptr = (m_g + 1) % N;
            end
            m_drop = 0;
            for (int i = 0; i < N; i++) begin
                if (m_ev[i]) begin
                    if (m_pend[i]) m_drop = 1;
                    else begin
                        m_pend[i] = 1;
                        m_prpt[i] = m_evr[i];
                    end
                end
            end
            if (m_drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            for (int i = 0; i < N; i++) m_prev[i] = btn_level[i];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking): inputs change only at the falling edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_tests++;
        if ({cmd_valid, cmd_id, cmd_repeat, ovf} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b id=%0d rpt=%b ovf=%b, want all 0",
                     cmd_valid, cmd_id, cmd_repeat, ovf);
        end
    endtask

    task automatic test_single_press();
        int vcnt = 0;
        int first = -1;
        logic [1:0] got_id = 2'd0;
        logic got_rpt = 1'b1;
        rpt_en = '0; cmd_ready = 1'b1;
        btn_level = 4'b0100;
        for (int c = 1; c <= 60; c++) begin
            if (c == 51) btn_level = '0;
            tick();
            if (cmd_valid) begin
                vcnt++;
                if (first < 0) begin
                    first = c; got_id = cmd_id; got_rpt = cmd_repeat;
                end
            end
        end
        n_tests++;
        if (vcnt !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d entries, want 1", vcnt);
        end
        n_tests++;
        if (first !== 2) begin
            n_fail++; $display("FAIL single_latency: valid at cycle %0d, want 2", first);
        end
        n_tests++;
        if (got_id !== 2'd2 || got_rpt !== 1'b0) begin
            n_fail++; $display("FAIL single_entry: got id=%0d rpt=%b, want id=2 rpt=0", got_id, got_rpt);
        end
    endtask

    task automatic test_repeat();
        int exp_t[5] = '{2, 22, 27, 32, 37};
        bit exp_r[5] = '{0, 1, 1, 1, 1};
        int t_q[$];
        bit r_q[$];
        int id_q[$];
        rpt_en = 4'b0010; cmd_ready = 1'b1;
        btn_level = 4'b0010;
        for (int c = 1; c <= 60; c++) begin
            if (c == 41) btn_level = '0;
            tick();
            if (cmd_valid) begin
                t_q.push_back(c); r_q.push_back(cmd_repeat); id_q.push_back(int'(cmd_id));
            end
        end
        n_tests++;
        if (t_q.size() !== 5) begin
            n_fail++; $display("FAIL repeat_count: got %0d entries, want 5", t_q.size());
        end
        for (int e = 0; e < 5; e++) begin
            if (e < t_q.size()) begin
                n_tests++;
                if (t_q[e] !== exp_t[e] || r_q[e] !== exp_r[e] || id_q[e] !== 1) begin
                    n_fail++;
                    $display("FAIL repeat_entry%0d: got t=%0d rpt=%b id=%0d, want t=%0d rpt=%b id=1",
                             e, t_q[e], r_q[e], id_q[e], exp_t[e], exp_r[e]);
                end
            end
        end
        rpt_en = '0;
    endtask

    task automatic test_round_robin();
        int id_q[$];
        int t_q[$];
        btn_level = '0; rpt_en = '0; cmd_ready = 1'b1;
        do_reset();
        btn_level = 4'b1011;
        for (int c = 1; c <= 10; c++) begin
            if (c == 7) btn_level = '0;
            tick();
            if (cmd_valid) begin
                id_q.push_back(int'(cmd_id)); t_q.push_back(c);
            end
        end
        n_tests++;
        if (id_q.size() !== 3 || id_q[0] !== 0 || id_q[1] !== 1 || id_q[2] !== 3 ||
            t_q[0] !== 2 || t_q[2] !== 4) begin
            n_fail++;
            $display("FAIL rr_three: got %0d entries ids=%p times=%p, want ids 0,1,3 at 2,3,4",
                     id_q.size(), id_q, t_q);
        end
        id_q.delete(); t_q.delete();
        btn_level = 4'b1001;
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) btn_level = '0;
            tick();
            if (cmd_valid) begin
                id_q.push_back(int'(cmd_id)); t_q.push_back(c);
            end
        end
        n_tests++;
        if (id_q.size() !== 2 || id_q[0] !== 0 || id_q[1] !== 3 || t_q[0] !== 2 || t_q[1] !== 3) begin
            n_fail++;
            $display("FAIL rr_wrap: got %0d entries ids=%p times=%p, want ids 0,3 at 2,3",
                     id_q.size(), id_q, t_q);
        end
    endtask

    task automatic test_fifo_full();
        int id_q[$];
        btn_level = '0; rpt_en = '0; cmd_ready = 1'b0;
        do_reset();
        btn_level = 4'b1111; ticks(6);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin
            n_fail++; $display("FAIL full_head: got valid=%b id=%0d, want valid=1 id=0", cmd_valid, cmd_id);
        end
        btn_level = '0;      ticks(2);
        btn_level = 4'b0011; ticks(3);
        n_tests++;
        if (ovf !== 1'b0 || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_pending: got ovf=%b valid=%b, want ovf=0 valid=1", ovf, cmd_valid);
        end
        btn_level = '0;      ticks(2);
        btn_level = 4'b0001; ticks(2);
        n_tests++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL full_drop_ovf: got ovf=%b, want 1", ovf);
        end
        btn_level = '0; tick();
        cmd_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (cmd_valid) id_q.push_back(int'(cmd_id));
            tick();
        end
        n_tests++;
        if (id_q.size() !== 6 || id_q[0] !== 0 || id_q[1] !== 1 || id_q[2] !== 2 ||
            id_q[3] !== 3 || id_q[4] !== 0 || id_q[5] !== 1) begin
            n_fail++; $display("FAIL full_drain: got %0d ids %p, want 0,1,2,3,0,1", id_q.size(), id_q);
        end
    endtask

    task automatic test_ovf_clear();
        cmd_ready = 1'b0; rpt_en = '0;
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr_alone1: got ovf=%b, want 0", ovf);
        end
        btn_level = 4'b1111; ticks(6);
        btn_level = '0;      ticks(2);
        btn_level = 4'b0001; ticks(2);
        btn_level = '0;      ticks(2);
        btn_level = 4'b0001; ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set_wins: got ovf=%b, want 1", ovf);
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clr_alone2: got ovf=%b, want 0", ovf);
        end
        btn_level = '0; cmd_ready = 1'b1; ticks(8);
        n_tests++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drain: got valid=%b, want 0", cmd_valid);
        end
    endtask

    task automatic test_reset_mid_repeat();
        btn_level = '0; rpt_en = '0; cmd_ready = 1'b0;
        do_reset();
        rpt_en = 4'b0100; btn_level = 4'b0100;
        ticks(25);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
            n_fail++; $display("FAIL midrpt_head: got valid=%b id=%0d rpt=%b, want 1,2,0",
                               cmd_valid, cmd_id, cmd_repeat);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (cmd_valid !== 1'b0 || ovf !== 1'b0 || cmd_id !== 2'd0) begin
            n_fail++; $display("FAIL midrpt_async: got valid=%b ovf=%b id=%0d, want 0,0,0",
                               cmd_valid, ovf, cmd_id);
        end
        ticks(2);
        rst = 1'b0;
        tick();
        n_tests++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrpt_early: got valid=%b one cycle after reset, want 0", cmd_valid);
        end
        tick();
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
            n_fail++; $display("FAIL midrpt_press: got valid=%b id=%0d rpt=%b, want 1,2,0",
                               cmd_valid, cmd_id, cmd_repeat);
        end
        btn_level = '0; rpt_en = '0;
    endtask

    task automatic test_random();
        logic       e_valid;
        logic [1:0] e_id;
        logic       e_rpt;
        int         fails_here = 0;
        btn_level = '0; rpt_en = '1; cmd_ready = 1'b0; ovf_clr = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            e_valid = (m_q.size() != 0);
            e_id    = e_valid ? 2'(m_q[0].id) : 2'd0;
            e_rpt   = e_valid ? m_q[0].rpt : 1'b0;
            n_tests++;
            if ({cmd_valid, cmd_id, cmd_repeat, ovf} !== {e_valid, e_id, e_rpt, m_ovf}) begin
                n_fail++;
                fails_here++;
                if (fails_here <= 10) begin
                    $display("FAIL random_c%0d: got v=%b id=%0d r=%b ovf=%b, want v=%b id=%0d r=%b ovf=%b",
                             c, cmd_valid, cmd_id, cmd_repeat, ovf, e_valid, e_id, e_rpt, m_ovf);
                end
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) btn_level[i] = ~btn_level[i];
                if ($urandom_range(0, 59) == 0) rpt_en[i]    = ~rpt_en[i];
            end
            if (((c / 300) % 2) == 1) cmd_ready = ($urandom_range(0, 3) == 0);
            else                      cmd_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            tick();
        end
        btn_level = '0; ovf_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_level = '0; rpt_en = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        test_reset();
        test_single_press();
        test_repeat();
        test_round_robin();
        test_fifo_full();
        test_ovf_clear();
        test_reset_mid_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_cmd_ctrl.md
Name: btn_cmd_ctrl

Overview:
- Sits between the per-button debouncers and the game logic.
- Takes N debounced, stable button levels and turns them into press events and hold-to-repeat events.
- Arbitrates simultaneous events round-robin and queues them in a small FIFO.
- Game FSM consumes events over a valid/ready handshake, one command per pop.

Parameters:
- N_BTN, 4, number of buttons; 2..8.
- REPEAT_DELAY_CYC, 12_500_000, hold cycles before first repeat (500 ms at 25 MHz).
- REPEAT_RATE_CYC, 2_500_000, cycles between subsequent repeats (100 ms at 25 MHz).
- FIFO_DEPTH, 4, command queue entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock (25 MHz).
- rst  in  1  asynchronous, active-high reset.
- btn_level  in  N_BTN  debounced stable levels; bit i = button i; already synchronous to clk.
- rpt_en  in  N_BTN  per-button auto-repeat enable; sampled every cycle.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd_id  out  $clog2(N_BTN)  button index of the head entry.
- cmd_repeat  out  1  head is a repeat event (0 = initial press).
- ovf  out  1  sticky flag: an event was lost.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async): FIFO empty, all button FSMs IDLE, all counters 0, pending bits 0, prev levels 0, RR pointer 0, ovf 0. Outputs cmd_valid=0, cmd_id=0, cmd_repeat=0.
- A button held through reset yields one press event after release of reset, because prev=0.
- Per-button FSM:
  - IDLE: on edge where btn_level[i]=1 and prev[i]=0, raise press event and go to HOLD. Counter cleared.
  - HOLD: counter increments each cycle.
    - If rpt_en[i]=0: stay in HOLD, counter held at 0.
    - If counter==REPEAT_DELAY_CYC-1: raise repeat event, clear counter, go to RPT.
  - RPT: counter increments. When counter==REPEAT_RATE_CYC-1: raise repeat event, clear counter.
    - rpt_en[i]=0 in RPT returns to HOLD with counter 0.
  - Any state: btn_level[i]=0 returns to IDLE and clears the counter the same edge. An already-pending event is NOT cancelled.
- Pending slots: one pending bit plus repeat-flag per button.
  - A new event for button i while pending[i]=1: event dropped, ovf set, existing entry kept unchanged.
- Arbiter:
  - Each cycle, if any pending bit is set and the FIFO is not full (evaluated at cycle start), grant the first pending index at or above the RR pointer, wrapping.
  - Push {id, repeat}, clear that pending bit, set pointer = grant+1 mod N_BTN.
  - At most one push per cycle.
  - FIFO full: no grant, pending bits held, no ovf.
  - An event arriving for button i in the same cycle its pending bit is granted is stored into the slot (not dropped).
- FIFO:
  - First-word-fall-through. cmd_valid = !empty.
  - cmd_id and cmd_repeat reflect the head entry; both 0 when empty.
  - Pop on cmd_valid & cmd_ready.
  - Push and pop in the same cycle are both allowed when not full.
  - When full, a pop frees a slot for the next cycle only (no same-cycle bypass).
  - Pointers wrap modulo FIFO_DEPTH; the count register distinguishes full from empty.
- Latency: edge k first samples btn_level=1, so pending is set at edge k, push at edge k+1, and cmd_valid=1 after edge k+1. This holds for an uncontended, non-full FIFO.
- ovf: set on any dropped event. Cleared by ovf_clr=1. Set wins if a set and a clear occur on the same edge.
- Counters must be wide enough for max(REPEAT_DELAY_CYC, REPEAT_RATE_CYC); no wrap in normal operation.

Test Plan:
All scenarios use REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, N_BTN=4, FIFO_DEPTH=4.

1. Press btn 2, rpt_en=0, cmd_ready=1, hold 50 cycles then release -> exactly one entry {id=2, repeat=0}. cmd_valid is high for one cycle, 2 edges after the press.
2. Hold btn 1 with rpt_en[1]=1 for 40 cycles, cmd_ready=1 -> entries: press at t+2, repeats at t+22, t+27, t+32, t+37 (+2 latency each). Release -> no further entries.
3. Buttons 0, 1 and 3 rise on the same edge, pointer=0, cmd_ready=1 -> order 0, 1, 3 on consecutive cycles. A further simultaneous press of 0 and 3 then yields order 0, 3 (pointer at 0 after wrap).
4. cmd_ready=0; press buttons 0,1,2,3, release, then press 0,1 again -> FIFO holds 0,1,2,3 and cmd_valid stays 1. The second presses stay pending with ovf=0. A third press of btn 0 sets ovf=1. Raising cmd_ready drains 0,1,2,3,0,1.
5. ovf_clr=1 on the same edge as a new drop -> ovf remains 1. ovf_clr alone -> ovf=0 next cycle.
6. Assert rst mid-repeat with FIFO holding 2 entries -> cmd_valid=0 and ovf=0 immediately. With the button still held, one press entry appears 2 cycles after rst deasserts.
